// File: rtl/cpu_pipe_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pipe_pkg
// Description : Shared definitions for the ID/EX pipeline stage: control bundle
//               bit positions, a packed view of the bundle, field encodings and
//               the destination-register decode helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pipe_pkg;

    localparam int CTRL_W        = 20;

    // Control bundle bit positions
    localparam int ALUOP_HI      = 19;
    localparam int ALUOP_LO      = 17;
    localparam int REGDEST_HI    = 16;
    localparam int REGDEST_LO    = 15;
    localparam int ALUSRC2_HI    = 14;
    localparam int ALUSRC2_LO    = 13;
    localparam int JUMP_HI       = 12;
    localparam int JUMP_LO       = 11;
    localparam int BRANCH_HI     = 10;
    localparam int BRANCH_LO     = 9;
    localparam int REGSRC_HI     = 8;
    localparam int REGSRC_LO     = 7;
    localparam int MWR_HI        = 6;
    localparam int MWR_LO        = 5;
    localparam int REGWRITE_BIT  = 4;
    localparam int ALUSRC1_BIT   = 3;
    localparam int ZERO_BIT      = 2;
    localparam int WORD_BYTE_BIT = 1;
    localparam int READ_REG2_BIT = 0;

    // Packed view of the same bundle, MSB first
    typedef struct packed {
        logic [2:0] alu_op;
        logic [1:0] reg_dest;
        logic [1:0] alu_src2;
        logic [1:0] jump;
        logic [1:0] branch_inst;
        logic [1:0] reg_src;
        logic [1:0] mem_write_read;
        logic       reg_write;
        logic       alu_src1;
        logic       zero;
        logic       word_byte;
        logic       read_reg_2;
    } ctrl_t;

    localparam logic [1:0] REGDEST_RT  = 2'b00;
    localparam logic [1:0] REGDEST_RD  = 2'b01;
    localparam logic [1:0] REGDEST_RA  = 2'b10;
    localparam logic [1:0] MEM_RD      = 2'b10;
    localparam logic [1:0] MEM_WR      = 2'b01;
    localparam logic [1:0] JUMP_JR     = 2'b10;
    localparam logic [1:0] ALUSRC2_REG = 2'b00;
    localparam logic [4:0] REG_RA      = 5'd31;

    // Write register selected by RegDest; encoding 11 means no destination.
    function automatic logic [4:0] dest_decode(input logic [1:0] reg_dest,
                                               input logic [4:0] rt,
                                               input logic [4:0] rd);
        logic [4:0] d;
        case (reg_dest)
            REGDEST_RT: d = rt;
            REGDEST_RD: d = rd;
            REGDEST_RA: d = REG_RA;
            default:    d = 5'd0;
        endcase
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/id_ex_pipe_load_use_detect.sv
`default_nettype none
// ============================================================================
// Module      : load_use_detect
// Description : Combinational load-use hazard detection. Works out which
//               register sources the ID instruction actually reads and compares
//               them with the write register of a load sitting in EX.
// Ports       : ex_*  - state of the instruction in EX (valid, mem op, RegWrite,
//                       resolved destination)
//               id_*  - valid flag, source-usage control fields and specifiers
//                       of the ID instruction
//               hazard - ID instruction depends on the load in EX
// Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import cpu_pipe_pkg::*;
(
    input  logic       ex_valid,
    input  logic [1:0] ex_mem_wr_rd,
    input  logic       ex_reg_write,
    input  logic [4:0] ex_dest,
    input  logic       id_valid,
    input  logic       id_alu_src1,
    input  logic [1:0] id_jump,
    input  logic [1:0] id_alu_src2,
    input  logic [1:0] id_mem_wr_rd,
    input  logic       id_read_reg_2,
    input  logic [4:0] id_rs,
    input  logic [4:0] id_rt,
    input  logic [4:0] id_rd,
    output logic       hazard
);

    logic       w_ex_load;
    logic       w_rs_used;
    logic       w_src2_used;
    logic [4:0] w_src2;

    // A load writing $0 produces nothing anyone can wait for.
    assign w_ex_load   = ex_valid & (ex_mem_wr_rd == MEM_RD) & ex_reg_write
                         & (ex_dest != 5'd0);

    // rs feeds the ALU, or is the jr target.
    assign w_rs_used   = id_alu_src1 | (id_jump == JUMP_JR);

    // Second read port: rd for the swn-style encodings, rt otherwise. It is
    // read either as ALU operand B or as store data.
    assign w_src2      = id_read_reg_2 ? id_rd : id_rt;
    assign w_src2_used = (id_alu_src2 == ALUSRC2_REG) | (id_mem_wr_rd == MEM_WR);

    assign hazard = w_ex_load & id_valid &
                    ((w_rs_used   & (id_rs  == ex_dest)) |
                     (w_src2_used & (w_src2 == ex_dest)));

endmodule
`default_nettype wire

// File: rtl/id_ex_pipe.sv
`default_nettype none
// ============================================================================
// Module      : id_ex_pipe
// Description : ID/EX pipeline register. Captures the decoded control bundle and
//               operand/field data, inserts a bubble on a load-use hazard or a
//               flush, and counts stall/flush events with saturating counters.
// Ports       : clk, rst_n      - clock, synchronous active-low reset
//               id_*            - decode-stage instruction and operands
//               flush           - kill the ID instruction (taken branch/jump)
//               ex_*            - registered view for the EX stage
//               ex_dest         - resolved write register of the EX instruction
//               stall_id        - combinational hold request to IF/ID
//               stall_cnt/flush_cnt - saturating event counters
// Revision    : 1.0 - initial release
// ============================================================================
module id_ex_pipe
    import cpu_pipe_pkg::*;
#(
    parameter int DW    = 32,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [19:0]       id_ctrl,
    input  logic [DW-1:0]     id_pc_plus4,
    input  logic [DW-1:0]     id_rs_data,
    input  logic [DW-1:0]     id_rt_data,
    input  logic [15:0]       id_imm,
    input  logic [4:0]        id_rs,
    input  logic [4:0]        id_rt,
    input  logic [4:0]        id_rd,
    input  logic [4:0]        id_shamt,
    input  logic              flush,
    output logic              ex_valid,
    output logic [19:0]       ex_ctrl,
    output logic [DW-1:0]     ex_pc_plus4,
    output logic [DW-1:0]     ex_rs_data,
    output logic [DW-1:0]     ex_rt_data,
    output logic [15:0]       ex_imm,
    output logic [4:0]        ex_rs,
    output logic [4:0]        ex_rt,
    output logic [4:0]        ex_rd,
    output logic [4:0]        ex_shamt,
    output logic [4:0]        ex_dest,
    output logic              stall_id,
    output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
);

    localparam logic [CNT_W-1:0] C_CNT_MAX = '1;
    localparam logic [CNT_W-1:0] C_CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic w_hazard;

    load_use_detect u_load_use_detect (
        .ex_valid      (ex_valid),
        .ex_mem_wr_rd  (ex_ctrl[MWR_HI:MWR_LO]),
        .ex_reg_write  (ex_ctrl[REGWRITE_BIT]),
        .ex_dest       (ex_dest),
        .id_valid      (id_valid),
        .id_alu_src1   (id_ctrl[ALUSRC1_BIT]),
        .id_jump       (id_ctrl[JUMP_HI:JUMP_LO]),
        .id_alu_src2   (id_ctrl[ALUSRC2_HI:ALUSRC2_LO]),
        .id_mem_wr_rd  (id_ctrl[MWR_HI:MWR_LO]),
        .id_read_reg_2 (id_ctrl[READ_REG2_BIT]),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .hazard        (w_hazard)
    );

    // The ID instruction is being killed anyway, so a flush masks the stall.
    assign stall_id = w_hazard & ~flush;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ex_valid    <= 1'b0;
            ex_ctrl     <= '0;
            ex_pc_plus4 <= '0;
            ex_rs_data  <= '0;
            ex_rt_data  <= '0;
            ex_imm      <= '0;
            ex_rs       <= '0;
            ex_rt       <= '0;
            ex_rd       <= '0;
            ex_shamt    <= '0;
            ex_dest     <= '0;
            stall_cnt   <= '0;
            flush_cnt   <= '0;
        end else if (flush) begin
            // Bubble; data fields keep their stale contents.
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_dest  <= '0;
            if (flush_cnt != C_CNT_MAX) begin
                flush_cnt <= flush_cnt + C_CNT_ONE;
            end
        end else if (w_hazard) begin
            // Bubble while the load completes; IF/ID holds the dependent op.
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            ex_dest  <= '0;
            if (stall_cnt != C_CNT_MAX) begin
                stall_cnt <= stall_cnt + C_CNT_ONE;
            end
        end else begin
            // An invalid ID slot still carries its control bits through;
            // ex_valid=0 is what makes it a bubble downstream.
            ex_valid    <= id_valid;
            ex_ctrl     <= id_ctrl;
            ex_pc_plus4 <= id_pc_plus4;
            ex_rs_data  <= id_rs_data;
            ex_rt_data  <= id_rt_data;
            ex_imm      <= id_imm;
            ex_rs       <= id_rs;
            ex_rt       <= id_rt;
            ex_rd       <= id_rd;
            ex_shamt    <= id_shamt;
            ex_dest     <= dest_decode(id_ctrl[REGDEST_HI:REGDEST_LO], id_rt, id_rd);
        end
    end

endmodule
`default_nettype wire

// File: doc/id_ex_pipe.md
Name: id_ex_pipe

Overview:
- ID/EX pipeline register for the 5-stage core, directly downstream of the decode control unit.
- Captures the decoded control bundle plus operand/field data each cycle and presents it to EX.
- Detects load-use hazards against the instruction already in EX: raises a stall to IF/ID and inserts a bubble.
- Honours a flush from EX branch/jump resolution and keeps saturating stall/flush event counters.

Parameters:
- DW, 32, datapath width (pc_plus4, rs_data, rt_data)
- CNT_W, 16, width of the stall_cnt/flush_cnt event counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  synchronous active-low reset
- id_valid  in  1  ID holds a real instruction
- id_ctrl  in  20  packed control bundle from decode (layout in package)
- id_pc_plus4  in  DW  PC+4 of the ID instruction
- id_rs_data, id_rt_data  in  DW each  register-file read data
- id_imm  in  16  immediate field
- id_rs, id_rt, id_rd  in  5 each  register specifiers
- id_shamt  in  5  shift amount
- flush  in  1  EX resolved a taken branch/jump; kill the ID instruction
- ex_valid  out  1  EX holds a real instruction
- ex_ctrl  out  20  registered control bundle
- ex_pc_plus4, ex_rs_data, ex_rt_data  out  DW each  registered data
- ex_imm  out  16; ex_rs, ex_rt, ex_rd, ex_shamt  out  5 each  registered fields
- ex_dest  out  5  resolved write register of the EX instruction
- stall_id  out  1  combinational; IF/ID must hold its contents this cycle
- stall_cnt, flush_cnt  out  CNT_W each  saturating event counters

Behaviour:
- Reset: when rst_n=0 at a rising edge, every registered output goes to 0, including ex_valid, ex_ctrl, counters and ex_dest. Reset wins over all other inputs. Reset mid-stall clears the stall on the next cycle.
- Latency: 1 cycle. ID values present at edge N appear on the ex_* outputs after edge N.
- Destination decode, registered into ex_dest: RegDest 00 gives rt, 01 gives rd, 10 gives 31, 11 gives 0.
- ID source usage:
  - rs is used when ALUsrc1=1 or jump=10 (jr).
  - The second source is rd if Read_reg_2=1, otherwise rt.
  - The second source is used when ALUsrc2=00 or Mem_Write_Read=01 (store data).
- Hazard condition, all of these true:
  - ex_valid and EX Mem_Write_Read=10 (load) and EX RegWrite=1 and ex_dest!=0
  - id_valid
  - ex_dest equals a used ID source
- stall_id = hazard AND NOT flush. Purely combinational, no register in the path.
- Next-state priority at each edge:
  1. reset
  2. flush: bubble, and flush_cnt += 1
  3. stall: bubble, and stall_cnt += 1
  4. otherwise capture all id_* values; ex_valid <= id_valid
- Bubble: ex_valid=0 and ex_ctrl=0 (RegWrite=0, Mem_Write_Read=00, jump=00, branch=00). Data fields may hold stale values, but ex_dest is forced to 0.
- Flush together with hazard: the flush wins, stall_id=0, only flush_cnt increments.
- A stall lasts exactly one cycle per load. After the bubble the load leaves EX, so the hazard clears on the next cycle with no re-stall.
- Counters saturate at 2^CNT_W-1 and never wrap.
- id_valid=0 never causes a stall. It is captured as a bubble-equivalent (ex_valid=0, but ex_ctrl is still captured).

Decomposition:
- Package cpu_pipe_pkg holds:
  - the ctrl bundle bit positions: ALUop[19:17], RegDest[16:15], ALUsrc2[14:13], jump[12:11], branch_inst[10:9], RegSrc[8:7], Mem_Write_Read[6:5], RegWrite[4], ALUsrc1[3], zero[2], word_byte[1], Read_reg_2[0]
  - constants REGDEST_RT/RD/RA, MEM_RD=2'b10, MEM_WR=2'b01, JUMP_JR=2'b10, REG_RA=5'd31
- One sub-module, load_use_detect: purely combinational source-usage and hazard compare. The register/counter logic stays in id_ex_pipe.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with random id_* inputs -> all outputs 0. Release; ID addi (ALUop=1, RegWrite=1, RegDest=00, rt=5) -> next cycle ex_valid=1, ex_dest=5.
- Load-use on rs:
  - Cycle 1: EX holds lw with rt=8.
  - Cycle 2: ID holds add with rs=8 -> stall_id=1 in cycle 2, ex_valid=0 and ex_ctrl=0 after the edge, stall_cnt=1.
  - Cycle 3: add is captured, stall_id=0.
- No stall cases:
  - lw dest $0 followed by add rs=0 -> stall_id=0.
  - lw rt=8 followed by addi with rt=8, where rt is only the destination -> stall_id=0.
- Store data hazard: lw rt=9, then swn with Read_reg_2=1, rd=9 -> stall_id=1. Same lw then sw with rt=9 -> stall_id=1.
- Flush with hazard in the same cycle -> stall_id=0, bubble captured, flush_cnt=1, stall_cnt unchanged.
- Counter saturation: CNT_W=2, 5 consecutive flushes -> flush_cnt reads 1,2,3,3,3.
